aes_inv_key_expansion: RTL



---
 rtl/aes_pkg.sv | 20 ++
 rtl/SubBytes.sv | 29 ++
 rtl/aes_inv_key_expansion.sv | 113 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES constants and the inverse key-expansion state encoding.
// Imported by the key-schedule blocks.
package aes_pkg;

    localparam int AES128_ROUNDS = 10;

    // Round constants indexed by round number; entry 0 is never used.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IKE_IDLE = 2'd0,
        IKE_EMIT = 2'd1,
        IKE_SUB  = 2'd2,
        IKE_XOR  = 2'd3
    } ike_state_e;

endpackage

// File: rtl/SubBytes.sv
// Combinational AES forward S-box, one byte per lookup.
// Shared by byte-serial key-schedule datapaths.
module SubBytes (
    input  logic [7:0] byte_in,
    output logic [7:0] byte_o
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign byte_o = SBOX[byte_in];

endmodule

// File: rtl/aes_inv_key_expansion.sv
// Inverse AES-128 key schedule: emits round keys 10 down to 0
// over valid/ready, deriving each previous key with one shared S-box.
module aes_inv_key_expansion (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_last,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [127:0] round_key_o,
    output logic [3:0]   round_o,
    output logic         busy,
    output logic         done
);

    import aes_pkg::*;

    ike_state_e       state_q, state_d;
    logic [127:0]     key_q, key_d;
    logic [0:3][7:0]  g_sub_q, g_sub_d;
    logic [3:0]       round_q, round_d;
    logic [1:0]       cnt_q, cnt_d;
    logic             done_q, done_d;

    logic [31:0]      k0, k1, k2, k3;
    logic [31:0]      p0, p1, p2, p3;
    logic [0:3][7:0]  rot_b;
    logic [7:0]       sb_in, sb_out;

    assign {k0, k1, k2, k3} = key_q;

    // Undo the forward word chaining; only w0 needs the S-box.
    assign p3 = k3 ^ k2;
    assign p2 = k2 ^ k1;
    assign p1 = k1 ^ k0;
    assign rot_b = {p3[23:0], p3[31:24]};
    assign sb_in = rot_b[cnt_q];
    assign p0 = k0 ^ (g_sub_q ^ {RCON[round_q], 24'h0});

    SubBytes u_sbox (
        .byte_in (sb_in),
        .byte_o  (sb_out)
    );

    // Next-state and datapath update for the four-state schedule walker.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        g_sub_d = g_sub_q;
        round_d = round_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IKE_IDLE: begin
                if (start) begin
                    key_d   = key_last;
                    round_d = 4'(AES128_ROUNDS);
                    state_d = IKE_EMIT;
                end
            end
            IKE_EMIT: begin
                if (key_ready) begin
                    if (round_q == 4'd0) begin
                        state_d = IKE_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = IKE_SUB;
                        cnt_d   = 2'd0;
                    end
                end
            end
            IKE_SUB: begin
                g_sub_d[cnt_q] = sb_out;
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    state_d = IKE_XOR;
                end
            end
            IKE_XOR: begin
                key_d   = {p0, p1, p2, p3};
                round_d = round_q - 4'd1;
                state_d = IKE_EMIT;
            end
            default: state_d = IKE_IDLE;
        endcase
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IKE_IDLE;
            key_q   <= '0;
            g_sub_q <= '0;
            round_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            g_sub_q <= g_sub_d;
            round_q <= round_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign key_valid   = (state_q == IKE_EMIT);
    assign busy        = (state_q != IKE_IDLE);
    assign done        = done_q;
    assign round_key_o = key_q;
    assign round_o     = round_q;

endmodule
